// File: rtl/mem_ports.sv
// Dual-port (fetch + data) byte-addressed memory with per-port IDLE/BUSY handshake and fixed latency.
module mem_ports #(
  parameter int MEM_SIZE  = 2048,
  parameter int ADDR_W    = 64,
  parameter int IBYTES    = 10,
  parameter int LATENCY   = 2,
  parameter     INIT_FILE = "irom.bin"
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ready,
  output logic                i_valid,
  output logic [8*IBYTES-1:0] i_insn,
  output logic                i_error,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [1:0]          d_size,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [63:0]         d_wdata,
  output logic                d_ready,
  output logic                d_valid,
  output logic [63:0]         d_rdata,
  output logic                d_error
);

  localparam int IDX_W = $clog2(MEM_SIZE);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W:0]  MEM_LIMIT = (ADDR_W+1)'(MEM_SIZE);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  logic [7:0] mem [MEM_SIZE];

  // ---------------- fetch port ----------------
  state_e              i_state_q, i_state_d;
  logic [CNT_W-1:0]    i_cnt_q, i_cnt_d;
  logic [ADDR_W-1:0]   i_addr_q, i_addr_d;
  logic                i_valid_q, i_valid_d;
  logic [8*IBYTES-1:0] i_insn_q, i_insn_d;
  logic                i_error_q, i_error_d;
  logic [ADDR_W:0]     i_end;
  logic                i_oob;
  logic [8*IBYTES-1:0] i_rd_bytes;

  assign i_end = {1'b0, i_addr_q} + (ADDR_W+1)'(IBYTES - 1);
  assign i_oob = (i_end >= MEM_LIMIT);

  always_comb begin
    i_rd_bytes = '0;
    for (int k = 0; k < IBYTES; k++)
      i_rd_bytes[8*(IBYTES-1-k) +: 8] = mem[IDX_W'(i_addr_q + ADDR_W'(k))];
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    i_state_d = i_state_q;
    i_cnt_d   = i_cnt_q;
    i_addr_d  = i_addr_q;
    i_valid_d = 1'b0;
    i_insn_d  = i_insn_q;
    i_error_d = i_error_q;
    case (i_state_q)
      IDLE: if (i_req) begin
        i_addr_d  = i_addr;
        i_cnt_d   = CNT_LOAD;
        i_state_d = BUSY;
      end
      BUSY: if (i_cnt_q == '0) begin
        i_state_d = IDLE;
        i_valid_d = 1'b1;
        i_error_d = i_oob;
        i_insn_d  = i_oob ? '0 : i_rd_bytes;
      end else begin
        i_cnt_d = i_cnt_q - 1'b1;
      end
      default: i_state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i_state_q <= IDLE;
      i_cnt_q   <= '0;
      i_addr_q  <= '0;
      i_valid_q <= 1'b0;
      i_insn_q  <= '0;
      i_error_q <= 1'b0;
    end else begin
      i_state_q <= i_state_d;
      i_cnt_q   <= i_cnt_d;
      i_addr_q  <= i_addr_d;
      i_valid_q <= i_valid_d;
      i_insn_q  <= i_insn_d;
      i_error_q <= i_error_d;
    end
  end

  assign i_ready = (i_state_q == IDLE);
  assign i_valid = i_valid_q;
  assign i_insn  = i_insn_q;
  assign i_error = i_error_q;

  // ---------------- data port ----------------
  state_e            d_state_q, d_state_d;
  logic [CNT_W-1:0]  d_cnt_q, d_cnt_d;
  logic [ADDR_W-1:0] d_addr_q, d_addr_d;
  logic [1:0]        d_size_q, d_size_d;
  logic              d_we_q, d_we_d;
  logic              d_valid_q, d_valid_d;
  logic [63:0]       d_rdata_q, d_rdata_d;
  logic              d_error_q, d_error_d;
  logic [3:0]        d_nbytes_q, d_in_nbytes;
  logic [ADDR_W:0]   d_end, d_in_end;
  logic              d_oob, d_in_oob, d_wr_en;
  logic [63:0]       d_rd_bytes, d_wdata_al;

  assign d_nbytes_q  = 4'd1 << d_size_q;
  assign d_end       = {1'b0, d_addr_q} + (ADDR_W+1)'(d_nbytes_q - 4'd1);
  assign d_oob       = (d_end >= MEM_LIMIT);
  assign d_in_nbytes = 4'd1 << d_size;
  assign d_in_end    = {1'b0, d_addr} + (ADDR_W+1)'(d_in_nbytes - 4'd1);
  assign d_in_oob    = (d_in_end >= MEM_LIMIT);
  assign d_wr_en     = (d_state_q == IDLE) && d_req && d_we && !d_in_oob;
  // Left-justify the write data so byte k of the access is always bits [63-8k -: 8].
  assign d_wdata_al  = d_wdata << (7'd64 - {d_in_nbytes, 3'b000});

  always_comb begin
    d_rd_bytes = '0;
    for (int k = 0; k < 8; k++)
      if (4'(k) < d_nbytes_q)
        d_rd_bytes = {d_rd_bytes[55:0], mem[IDX_W'(d_addr_q + ADDR_W'(k))]};
  end

  always_comb begin
    d_state_d = d_state_q;
    d_cnt_d   = d_cnt_q;
    d_addr_d  = d_addr_q;
    d_size_d  = d_size_q;
    d_we_d    = d_we_q;
    d_valid_d = 1'b0;
    d_rdata_d = d_rdata_q;
    d_error_d = d_error_q;
    case (d_state_q)
      IDLE: if (d_req) begin
        d_addr_d  = d_addr;
        d_size_d  = d_size;
        d_we_d    = d_we;
        d_cnt_d   = CNT_LOAD;
        d_state_d = BUSY;
      end
      BUSY: if (d_cnt_q == '0) begin
        d_state_d = IDLE;
        d_valid_d = 1'b1;
        d_error_d = d_oob;
        d_rdata_d = (d_oob || d_we_q) ? 64'd0 : d_rd_bytes;
      end else begin
        d_cnt_d = d_cnt_q - 1'b1;
      end
      default: d_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_state_q <= IDLE;
      d_cnt_q   <= '0;
      d_addr_q  <= '0;
      d_size_q  <= '0;
      d_we_q    <= 1'b0;
      d_valid_q <= 1'b0;
      d_rdata_q <= '0;
      d_error_q <= 1'b0;
    end else begin
      d_state_q <= d_state_d;
      d_cnt_q   <= d_cnt_d;
      d_addr_q  <= d_addr_d;
      d_size_q  <= d_size_d;
      d_we_q    <= d_we_d;
      d_valid_q <= d_valid_d;
      d_rdata_q <= d_rdata_d;
      d_error_q <= d_error_d;
    end
  end

  // NOTE: the storage array has no reset; its contents survive reset and it maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (d_wr_en)
      for (int k = 0; k < 8; k++)
        if (4'(k) < d_in_nbytes)
          mem[IDX_W'(d_addr + ADDR_W'(k))] <= d_wdata_al[63-8*k -: 8];
  end

  assign d_ready = (d_state_q == IDLE);
  assign d_valid = d_valid_q;
  assign d_rdata = d_rdata_q;
  assign d_error = d_error_q;

endmodule

// File: tb/tb_mem_ports.sv
// Scoreboard bench for mem_ports: drivers push expected responses, a negedge monitor pops and compares.
module tb_mem_ports;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req;
  logic [63:0] i_addr;
  logic        i_ready, i_valid, i_error;
  logic [79:0] i_insn;
  logic        d_req, d_we;
  logic [1:0]  d_size;
  logic [63:0] d_addr, d_wdata;
  logic        d_ready, d_valid, d_error;
  logic [63:0] d_rdata;

  typedef struct { logic [79:0] insn; logic err; } i_exp_t;
  typedef struct { logic [63:0] data; logic err; } d_exp_t;

  i_exp_t iq[$];
  d_exp_t dq[$];
  int     d_times[$];
  int     cyc = 0;
  int     tests = 0;
  int     fails = 0;

  mem_ports dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_valid(i_valid),
    .i_insn(i_insn), .i_error(i_error),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_valid(d_valid), .d_rdata(d_rdata), .d_error(d_error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every response against the oldest expectation of its port.
  always @(negedge clock) begin
    if (i_valid) begin
      if (iq.size() == 0) begin
        tests++; fails++;
        $display("FAIL i_unexpected: got i_valid with insn %h, expected no response", i_insn);
      end else begin
        i_exp_t e;
        e = iq.pop_front();
        check("i_insn", 128'(i_insn), 128'(e.insn));
        check("i_error", 128'(i_error), 128'(e.err));
      end
    end
    if (d_valid) begin
      d_times.push_back(cyc);
      if (dq.size() == 0) begin
        tests++; fails++;
        $display("FAIL d_unexpected: got d_valid with rdata %h, expected no response", d_rdata);
      end else begin
        d_exp_t e;
        e = dq.pop_front();
        check("d_rdata", 128'(d_rdata), 128'(e.data));
        check("d_error", 128'(d_error), 128'(e.err));
      end
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while ((iq.size() != 0 || dq.size() != 0) && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({name, "_drain"}, 128'(iq.size() + dq.size()), 128'd0);
  endtask

  task automatic d_op(input logic we, input logic [1:0] sz, input logic [63:0] a,
                      input logic [63:0] wd, input logic [63:0] exp_d, input logic exp_e);
    int n = 0;
    @(negedge clock);
    while (!d_ready && n < 20) begin @(negedge clock); n++; end
    check("d_ready_wait", 128'(d_ready), 128'd1);
    d_req = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
    dq.push_back('{exp_d, exp_e});
    @(posedge clock); #1;
    d_req = 1'b0;
    wait_drain("d_op");
  endtask

  task automatic i_op(input logic [63:0] a, input logic [79:0] exp_i, input logic exp_e);
    int n = 0;
    @(negedge clock);
    while (!i_ready && n < 20) begin @(negedge clock); n++; end
    check("i_ready_wait", 128'(i_ready), 128'd1);
    i_req = 1'b1; i_addr = a;
    iq.push_back('{exp_i, exp_e});
    @(posedge clock); #1;
    i_req = 1'b0;
    wait_drain("i_op");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clock);
    check("rst_ready", 128'({i_ready, d_ready}), 128'(2'b11));
    check("rst_valid_err", 128'({i_valid, d_valid, i_error, d_error}), 128'd0);
    check("rst_data", 128'({i_insn, d_rdata}), 128'd0);
    reset = 1'b1;

    // Preload the fetch image at 0..15 through the data port.
    d_op(1'b1, 2'd3, 64'd0, 64'h30F20A0000000000, 64'd0, 1'b0);
    d_op(1'b1, 2'd3, 64'd8, 64'd0, 64'd0, 1'b0);

    // Fetch timing at LATENCY=2.
    @(negedge clock);
    i_req = 1'b1; i_addr = 64'd0;
    iq.push_back('{80'h30F20A00000000000000, 1'b0});
    @(posedge clock); #1; i_req = 1'b0;
    check("fetch_ready_E0", 128'(i_ready), 128'd0);
    @(posedge clock); #1;
    check("fetch_E1", 128'({i_ready, i_valid}), 128'(2'b00));
    @(posedge clock); #1;
    check("fetch_E2", 128'({i_ready, i_valid}), 128'(2'b11));
    wait_drain("fetch");

    // Write 8B then read 2B from the middle.
    d_op(1'b1, 2'd3, 64'h100, 64'h1122334455667788, 64'd0, 1'b0);
    d_op(1'b0, 2'd1, 64'h102, 64'd0, 64'h3344, 1'b0);

    // Bounds near the top of memory.
    d_op(1'b1, 2'd3, 64'd2040, 64'h0102030405060708, 64'd0, 1'b0);
    d_op(1'b1, 2'd1, 64'd2038, 64'hA1A2, 64'd0, 1'b0);
    i_op(64'd2039, 80'd0, 1'b1);
    i_op(64'd2038, 80'hA1A20102030405060708, 1'b0);
    d_op(1'b1, 2'd3, 64'd2041, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1);
    d_op(1'b0, 2'd3, 64'd2040, 64'd0, 64'h0102030405060708, 1'b0);
    d_op(1'b0, 2'd0, 64'd2047, 64'd0, 64'h08, 1'b0);
    d_op(1'b0, 2'd2, 64'hFFFFFFFFFFFFFFFE, 64'd0, 64'd0, 1'b1);

    // Write accept on the same edge as a fetch response: fetch sees old mem[5].
    @(negedge clock);
    i_req = 1'b1; i_addr = 64'd0;
    iq.push_back('{80'h30F20A00000000000000, 1'b0});
    @(posedge clock); #1; i_req = 1'b0;
    @(posedge clock); @(negedge clock);
    d_req = 1'b1; d_we = 1'b1; d_size = 2'd0; d_addr = 64'd5; d_wdata = 64'hAA;
    dq.push_back('{64'd0, 1'b0});
    @(posedge clock); #1; d_req = 1'b0;
    wait_drain("concurrent");
    i_op(64'd0, 80'h30F20A0000AA00000000, 1'b0);
    d_op(1'b0, 2'd0, 64'd5, 64'd0, 64'hAA, 1'b0);

    // Reset during BUSY of an 8B read: dropped, no response.
    d_times.delete();
    @(negedge clock);
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd3; d_addr = 64'h100;
    @(posedge clock); #1; d_req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_ready", 128'({i_ready, d_ready}), 128'(2'b11));
    check("midrst_valid_err", 128'({i_valid, d_valid, i_error, d_error}), 128'd0);
    check("midrst_data", 128'({i_insn, d_rdata}), 128'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    check("midrst_no_valid", 128'(d_times.size()), 128'd0);
    check("midrst_ready_after", 128'(d_ready), 128'd1);
    d_op(1'b0, 2'd3, 64'h100, 64'd0, 64'h1122334455667788, 1'b0);

    // Back-to-back: d_req held for 12 edges yields 4 responses, 3 cycles apart.
    d_times.delete();
    for (int k = 0; k < 4; k++) dq.push_back('{64'h3344, 1'b0});
    @(negedge clock);
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd1; d_addr = 64'h102;
    repeat (12) @(posedge clock);
    #1; d_req = 1'b0;
    repeat (4) @(negedge clock);
    check("b2b_count", 128'(d_times.size()), 128'd4);
    for (int k = 1; k < d_times.size(); k++)
      check("b2b_spacing", 128'(d_times[k] - d_times[k-1]), 128'd3);
    check("final_queues", 128'(iq.size() + dq.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
